// File: rtl/dac_playback_ctrl.sv
// Paces show-ahead FIFO samples into the DAC register at a programmable rate.
// Define DAC_UNDERRUN_STOP_EN to make a RUN underrun stop playback.
module dac_playback_ctrl #(
    parameter int                DATA_W        = 16,
    parameter int                DIV_W         = 16,
    parameter int                SETTLE_CYCLES = 64,
    parameter logic [DATA_W-1:0] MIDSCALE      = 16'h8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_fifo_cmd,
    input  logic              start_dac_cmd,
    input  logic              stop_dac_cmd,
    input  logic [DIV_W-1:0]  sample_div,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              DAC_running,
    output logic              ADC_ready,
    output logic              underrun
);

    localparam int SET_W =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SETTLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               rdreq_q, rdreq_d;
    logic               undr_q, undr_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [SET_W-1:0]   set_q, set_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= MIDSCALE;
            valid_q <= 1'b0;
            rdreq_q <= 1'b0;
            undr_q  <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rdreq_q <= rdreq_d;
            undr_q  <= undr_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = 1'b0;
        rdreq_d = 1'b0;
        undr_d  = undr_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        set_d   = set_q;
        if (stop_dac_cmd) begin
            state_d = IDLE;
            data_d  = MIDSCALE;
            valid_d = 1'b1;
            div_d   = '0;
            cnt_d   = '0;
            set_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_fifo_cmd) begin
                        state_d = ARMED;
                        undr_d  = 1'b0;
                    end
                end
                ARMED: begin
                    if (start_fifo_cmd)
                        undr_d = 1'b0;
                    if (start_dac_cmd) begin
                        if (fifo_empty) begin
                            undr_d = 1'b1;
                        end else begin
                            state_d = SETTLE;
                            data_d  = fifo_q;
                            valid_d = 1'b1;
                            rdreq_d = 1'b1;
                            set_d   = '0;
                            cnt_d   = '0;
                            // Zero would allow back-to-back pops.
                            div_d   = (sample_div == '0) ?
                                      DIV_W'(1) : sample_div;
                        end
                    end
                end
                SETTLE: begin
                    if (set_q == SET_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        set_d = set_q + 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q == div_q) begin
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            data_d  = fifo_q;
                            valid_d = 1'b1;
                            rdreq_d = 1'b1;
                        end else begin
                            undr_d = 1'b1;
`ifdef DAC_UNDERRUN_STOP_EN
                            state_d = IDLE;
                            data_d  = MIDSCALE;
                            valid_d = 1'b1;
                            div_d   = '0;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fifo_rdreq  = rdreq_q;
    assign dac_data    = data_q;
    assign dac_valid   = valid_q;
    assign underrun    = undr_q;
    assign DAC_running = (state_q == SETTLE) || (state_q == RUN);
    assign ADC_ready   = (state_q == RUN);

endmodule
